serial_tx_shifter: RTL and testbench

Parallel-to-serial shifter that feeds the single-bit serial input of the downstream bit-pattern detector. It accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock. A one-word holding buffer allows back-to-back words to stream with no idle cycle between them. When no word is in flight, the serial output sits at a fixed idle level, so the detector sees a defined input.

---
 rtl/serial_tx_shifter.sv | 103 ++++++++++
 tb/tb_serial_tx_shifter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial shifter with a one-word holding buffer, so words can stream back-to-back.
// dout is forced to IDLE_LEVEL whenever no data bit is being shifted out.
module serial_tx_shifter #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_last,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;
    logic [WIDTH-1:0] sh_shifted;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        accept      = data_valid && !hold_full_q;
        sh_shifted  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
        case (state_q)
            IDLE: begin
                // The hold buffer is always empty here, so an accepted word goes straight to sh.
                if (accept) begin
                    sh_d    = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    sh_d  = sh_shifted;
                    if (accept) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    // Word offered during the last bit bypasses hold to keep the stream gap-free.
                    sh_d  = data_in;
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_ready = !hold_full_q;
        dout_valid = (state_q == SHIFT);
        word_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        busy       = (state_q == SHIFT) || hold_full_q;
        if (state_q == SHIFT) begin
            dout = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
        end else begin
            dout = IDLE_LEVEL;
        end
    end
endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed bench for serial_tx_shifter: an 8-bit MSB-first instance checked by a
// queue-based monitor, plus a 4-bit LSB-first instance checked inline.
module tb_serial_tx_shifter;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, dout, dout_valid, word_last, busy;

  logic [3:0] d4_in;
  logic       d4_valid;
  logic       d4_ready, d4_dout, d4_dv, d4_last, d4_busy;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [1:0] exp_q[$];  // {word_last, dout}

  always #5 clk = ~clk;

  serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .dout(dout), .dout_valid(dout_valid),
    .word_last(word_last), .busy(busy)
  );

  serial_tx_shifter #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut4 (
    .clk(clk), .reset(reset), .data_in(d4_in), .data_valid(d4_valid),
    .data_ready(d4_ready), .dout(d4_dout), .dout_valid(d4_dv),
    .word_last(d4_last), .busy(d4_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offers w until accepted; expected bits (MSB first) are queued right after the accept edge.
  task automatic send_word(input logic [7:0] w);
    bit done = 1'b0;
    data_in    = w;
    data_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (data_ready) begin
        @(posedge clk); #1;
        for (int b = 7; b >= 0; b--) exp_q.push_back({(b == 0), w[b]});
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: any pending expected bit must be on dout this cycle; otherwise the line is idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_valid || exp_q.size() > 0) begin
        chk("dout_valid", dout_valid, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", dout_valid, 0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("dout", dout, e[0]);
          chk("word_last", word_last, e[1]);
          chk("busy_active", busy, 1);
        end
      end else begin
        chk("idle_dout", dout, 0);
        chk("idle_last", word_last, 0);
        chk("idle_busy", busy, 0);
      end
    end
  end

  initial begin
    bit found;
    logic [3:0] w4;
    reset = 1'b1; data_valid = 1'b0; data_in = '0; d4_valid = 1'b0; d4_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_word_last", word_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_ready, 1);
    chk("rst4_ready", d4_ready, 1);
    chk("rst4_valid", d4_dv, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Single word
    send_word(8'hB0);
    data_valid = 1'b0;
    repeat (10) @(posedge clk); #1;

    // Back-to-back with a third word stalled behind hold
    send_word(8'hA5);
    send_word(8'h3C);
    @(negedge clk);
    chk("ready_low_hold", data_ready, 0);
    chk("busy_hold", busy, 1);
    send_word(8'h5A);
    data_valid = 1'b0;
    repeat (30) @(posedge clk); #1;

    // Last-bit bypass
    send_word(8'hFF);
    data_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (word_last) found = 1'b1;
    end
    chk("found_last", found, 1);
    send_word(8'h01);
    data_valid = 1'b0;
    repeat (9) begin
      @(negedge clk);
      chk("bypass_ready", data_ready, 1);
    end

    // Idle gap
    @(posedge clk); #1;
    send_word(8'h80);
    data_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("gap_valid", dout_valid, 0);
    chk("gap_dout", dout, 0);
    chk("gap_busy", busy, 0);
    chk("gap_ready", data_ready, 1);

    // Reset mid-word with a held word, and an accept attempt during reset
    @(posedge clk); #1;
    send_word(8'hF0);
    send_word(8'h0F);
    data_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1; data_valid = 1'b1; data_in = 8'hAA;
    @(posedge clk); #1;
    exp_q.delete();
    reset = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    chk("mrst_valid", dout_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", data_ready, 1);
    chk("mrst_dout", dout, 0);
    @(posedge clk); #1;
    send_word(8'hB0);
    data_valid = 1'b0;
    repeat (12) @(posedge clk); #1;

    // LSB-first, WIDTH=4: 4'b1101 -> 1,0,1,1
    w4 = 4'b1101;
    chk("w4_ready", d4_ready, 1);
    d4_in = w4; d4_valid = 1'b1;
    @(posedge clk); #1;
    d4_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w4_valid", d4_dv, 1);
      chk("w4_dout", d4_dout, (i == 1) ? 0 : 1);
      chk("w4_last", d4_last, (i == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("w4_done", d4_dv, 0);
    chk("w4_idle_dout", d4_dout, 0);

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
